// File: rtl/pipelined_control_unit_if.sv
// ID/EX/MEM/WB control bundle between the pipelined control unit and its datapath.
// The datapath side drives instruction, stall and EX flags; the control unit drives the rest.
interface pipelined_control_unit_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ALU_CTRL_WIDTH = 4,
   parameter int IMM_SRC_WIDTH  = 3
);
   logic [DATA_WIDTH-1:0]     instr_i;
   logic                      stall_i;
   logic                      zero_i;
   logic                      lt_i;
   logic                      ltu_i;
   logic [IMM_SRC_WIDTH-1:0]  imm_src_id_o;
   logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_ex_o;
   logic                      alu_src_ex_o;
   logic                      alu_a_pc_ex_o;
   logic [1:0]                result_src_ex_o;
   logic                      reg_write_ex_o;
   logic [1:0]                pc_src_ex_o;
   logic                      flush_o;
   logic                      illegal_ex_o;
   logic [1:0]                mem_write_mem_o;
   logic                      reg_write_mem_o;
   logic                      reg_write_wb_o;
   logic [1:0]                result_src_wb_o;
   logic [2:0]                load_type_wb_o;

   modport master (
      output instr_i, stall_i, zero_i, lt_i, ltu_i,
      input  imm_src_id_o, alu_ctrl_ex_o, alu_src_ex_o, alu_a_pc_ex_o,
      input  result_src_ex_o, reg_write_ex_o, pc_src_ex_o, flush_o,
      input  illegal_ex_o, mem_write_mem_o, reg_write_mem_o,
      input  reg_write_wb_o, result_src_wb_o, load_type_wb_o
   );

   modport slave (
      input  instr_i, stall_i, zero_i, lt_i, ltu_i,
      output imm_src_id_o, alu_ctrl_ex_o, alu_src_ex_o, alu_a_pc_ex_o,
      output result_src_ex_o, reg_write_ex_o, pc_src_ex_o, flush_o,
      output illegal_ex_o, mem_write_mem_o, reg_write_mem_o,
      output reg_write_wb_o, result_src_wb_o, load_type_wb_o
   );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I control for a 5-stage pipeline: ID decode, ID/EX/MEM/WB control registers,
// EX branch/jump resolution and front-end flush.
module pipelined_control_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ALU_CTRL_WIDTH = 4,
   parameter int IMM_SRC_WIDTH  = 3
) (
   input logic clk_i,
   input logic rst_ni,
   pipelined_control_unit_if.slave bus
);
   typedef logic [ALU_CTRL_WIDTH-1:0] alu_t;
   typedef logic [IMM_SRC_WIDTH-1:0]  imm_t;

   localparam alu_t ALU_ADD  = alu_t'(0);
   localparam alu_t ALU_SUB  = alu_t'(1);
   localparam alu_t ALU_AND  = alu_t'(2);
   localparam alu_t ALU_OR   = alu_t'(3);
   localparam alu_t ALU_XOR  = alu_t'(4);
   localparam alu_t ALU_SLL  = alu_t'(5);
   localparam alu_t ALU_SRL  = alu_t'(6);
   localparam alu_t ALU_SRA  = alu_t'(7);
   localparam alu_t ALU_SLT  = alu_t'(8);
   localparam alu_t ALU_SLTU = alu_t'(9);
   localparam alu_t ALU_PASS = alu_t'(10);

   localparam imm_t IMM_I = imm_t'(0);
   localparam imm_t IMM_S = imm_t'(1);
   localparam imm_t IMM_B = imm_t'(2);
   localparam imm_t IMM_J = imm_t'(3);
   localparam imm_t IMM_U = imm_t'(4);

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] mem_write;
      logic [2:0] load_type;
      alu_t       alu_ctrl;
      logic       alu_src;
      logic       alu_a_pc;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic [2:0] funct3;
      logic       illegal;
   } id_ex_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] mem_write;
      logic [2:0] load_type;
   } ex_mem_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic [2:0] load_type;
   } mem_wb_t;

   logic [6:0] op;
   logic [2:0] f3;
   logic [4:0] rd;
   logic       alt;
   logic       unused_bits;

   assign op          = bus.instr_i[6:0];
   assign rd          = bus.instr_i[11:7];
   assign f3          = bus.instr_i[14:12];
   assign alt         = bus.instr_i[30];
   assign unused_bits = ^{bus.instr_i[DATA_WIDTH-1:31], bus.instr_i[29:15]};

   function automatic alu_t alu_of(input logic [2:0] f, input logic sub_ok,
                                   input logic a);
      alu_t r;
      case (f)
         3'b000:  r = (a && sub_ok) ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = a ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   id_ex_t d;
   imm_t   imm_src;
   logic   bad;

   always_comb begin
      d       = '0;
      imm_src = IMM_I;
      bad     = 1'b0;
      unique case (1'b1)
         (op == 7'b0000011): begin
            d.reg_write  = 1'b1;
            d.result_src = 2'b01;
            d.alu_src    = 1'b1;
            d.alu_ctrl   = ALU_ADD;
            case (f3)
               3'b000:  d.load_type = 3'b011;
               3'b001:  d.load_type = 3'b010;
               3'b010:  d.load_type = 3'b001;
               3'b100:  d.load_type = 3'b111;
               3'b101:  d.load_type = 3'b110;
               default: bad = 1'b1;
            endcase
         end
         (op == 7'b0100011): begin
            imm_src   = IMM_S;
            d.alu_src = 1'b1;
            case (f3)
               3'b000:  d.mem_write = 2'b11;
               3'b001:  d.mem_write = 2'b10;
               3'b010:  d.mem_write = 2'b01;
               default: bad = 1'b1;
            endcase
         end
         (op == 7'b0110011): begin
            d.reg_write = 1'b1;
            d.alu_ctrl  = alu_of(f3, 1'b1, alt);
         end
         (op == 7'b0010011): begin
            d.reg_write = 1'b1;
            d.alu_src   = 1'b1;
            d.alu_ctrl  = alu_of(f3, 1'b0, alt);
         end
         (op == 7'b1100011): begin
            imm_src    = IMM_B;
            d.alu_ctrl = ALU_SUB;
            d.branch   = 1'b1;
            d.funct3   = f3;
            bad        = (f3 == 3'b010) || (f3 == 3'b011);
         end
         (op == 7'b1101111): begin
            imm_src      = IMM_J;
            d.reg_write  = 1'b1;
            d.result_src = 2'b10;
            d.jump       = 1'b1;
         end
         (op == 7'b1100111): begin
            d.reg_write  = 1'b1;
            d.result_src = 2'b10;
            d.alu_src    = 1'b1;
            d.jalr       = 1'b1;
         end
         (op == 7'b0110111): begin
            imm_src     = IMM_U;
            d.reg_write = 1'b1;
            d.alu_ctrl  = ALU_PASS;
            d.alu_src   = 1'b1;
         end
         (op == 7'b0010111): begin
            imm_src     = IMM_U;
            d.reg_write = 1'b1;
            d.alu_src   = 1'b1;
            d.alu_a_pc  = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (rd == 5'd0) d.reg_write = 1'b0;
      // an illegal encoding travels as a bubble so it can never write state
      if (bad) begin
         d         = '0;
         d.illegal = 1'b1;
      end
   end

   id_ex_t  ex_q;
   ex_mem_t mem_q;
   mem_wb_t wb_q;
   logic    taken;
   logic [1:0] pc_src;
   logic    flush;

   always_comb begin
      case (ex_q.funct3)
         3'b000:  taken = bus.zero_i;
         3'b001:  taken = !bus.zero_i;
         3'b100:  taken = bus.lt_i;
         3'b101:  taken = !bus.lt_i;
         3'b110:  taken = bus.ltu_i;
         3'b111:  taken = !bus.ltu_i;
         default: taken = 1'b0;
      endcase
      pc_src = 2'b00;
      if (ex_q.jump) pc_src = 2'b01;
      else if (ex_q.jalr) pc_src = 2'b10;
      else if (ex_q.branch && taken) pc_src = 2'b01;
      flush = |pc_src;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= (flush || bus.stall_i) ? '0 : d;
         mem_q <= '{ex_q.reg_write, ex_q.result_src, ex_q.mem_write, ex_q.load_type};
         wb_q  <= '{mem_q.reg_write, mem_q.result_src, mem_q.load_type};
      end
   end

   assign bus.imm_src_id_o    = imm_src;
   assign bus.alu_ctrl_ex_o   = ex_q.alu_ctrl;
   assign bus.alu_src_ex_o    = ex_q.alu_src;
   assign bus.alu_a_pc_ex_o   = ex_q.alu_a_pc;
   assign bus.result_src_ex_o = ex_q.result_src;
   assign bus.reg_write_ex_o  = ex_q.reg_write;
   assign bus.pc_src_ex_o     = pc_src;
   assign bus.flush_o         = flush;
   assign bus.illegal_ex_o    = ex_q.illegal;
   assign bus.mem_write_mem_o = mem_q.mem_write;
   assign bus.reg_write_mem_o = mem_q.reg_write;
   assign bus.reg_write_wb_o  = wb_q.reg_write;
   assign bus.result_src_wb_o = wb_q.result_src;
   assign bus.load_type_wb_o  = wb_q.load_type;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed plan followed by random instruction
// streams, all compared against an instruction-level model of the pipeline.
module tb_pipelined_control_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipelined_control_unit_if bus ();
   pipelined_control_unit dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] SW     = 32'h0020A023;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] ADDI   = 32'h00500093;
   localparam logic [31:0] BEQ    = 32'h00000463;
   localparam logic [31:0] BGEU   = 32'h0000F463;
   localparam logic [31:0] LBU    = 32'h00004283;
   localparam logic [31:0] JALR   = 32'h000100E7;
   localparam logic [31:0] ADDI0  = 32'h00100013;
   localparam logic [31:0] AUIPC  = 32'h00001197;
   localparam logic [31:0] LUI    = 32'h00001237;
   localparam logic [31:0] BADOP  = 32'h0000007F;

   // kind: 0 plain, 1 branch, 2 jal, 3 jalr
   typedef struct packed {
      bit       rw;
      bit [1:0] rs;
      bit [1:0] mw;
      bit [2:0] lt;
      bit [3:0] alu;
      bit       asrc;
      bit       apc;
      bit       ill;
      bit [1:0] kind;
      bit [2:0] f3;
      bit [2:0] imm;
   } exp_t;

   exp_t ex_m, mem_m, wb_m;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t ref_dec(input logic [31:0] ins);
      exp_t     e = '0;
      bit       bad = 1'b0;
      bit [2:0] f = ins[14:12];
      bit [2:0] im;
      bit [3:0] tab [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
      case (ins[6:0])
         7'h03: begin
            e.rw = 1; e.rs = 1; e.asrc = 1;
            case (f)
               3'd0: e.lt = 3'b011;
               3'd1: e.lt = 3'b010;
               3'd2: e.lt = 3'b001;
               3'd4: e.lt = 3'b111;
               3'd5: e.lt = 3'b110;
               default: bad = 1;
            endcase
         end
         7'h23: begin
            e.imm = 1; e.asrc = 1;
            if (f < 3) e.mw = 2'(3 - f); else bad = 1;
         end
         7'h33: begin
            e.rw = 1; e.alu = tab[f];
            if (ins[30] && f == 0) e.alu = 1;
            if (ins[30] && f == 5) e.alu = 7;
         end
         7'h13: begin
            e.rw = 1; e.asrc = 1; e.alu = tab[f];
            if (ins[30] && f == 5) e.alu = 7;
         end
         7'h63: begin
            e.imm = 2; e.alu = 1; e.kind = 1; e.f3 = f;
            if (f == 2 || f == 3) bad = 1;
         end
         7'h6F: begin e.imm = 3; e.rs = 2; e.rw = 1; e.kind = 2; end
         7'h67: begin e.asrc = 1; e.rs = 2; e.rw = 1; e.kind = 3; end
         7'h37: begin e.imm = 4; e.alu = 10; e.asrc = 1; e.rw = 1; end
         7'h17: begin e.imm = 4; e.asrc = 1; e.apc = 1; e.rw = 1; end
         default: bad = 1;
      endcase
      if (ins[11:7] == 5'd0) e.rw = 0;
      if (bad) begin
         im = e.imm;
         e = '0;
         e.ill = 1;
         e.imm = im;
      end
      return e;
   endfunction

   function automatic bit [1:0] ref_pc(input exp_t e);
      bit t;
      if (e.kind == 2) return 2'b01;
      if (e.kind == 3) return 2'b10;
      if (e.kind != 1) return 2'b00;
      case (e.f3)
         3'd0: t = bus.zero_i;
         3'd1: t = !bus.zero_i;
         3'd4: t = bus.lt_i;
         3'd5: t = !bus.lt_i;
         3'd6: t = bus.ltu_i;
         3'd7: t = !bus.ltu_i;
         default: t = 0;
      endcase
      return t ? 2'b01 : 2'b00;
   endfunction

   task automatic compare_all();
      bit [1:0] pc = ref_pc(ex_m);
      check("imm_src_id", bus.imm_src_id_o, ref_dec(bus.instr_i).imm);
      check("alu_ctrl_ex", bus.alu_ctrl_ex_o, ex_m.alu);
      check("alu_src_ex", bus.alu_src_ex_o, ex_m.asrc);
      check("alu_a_pc_ex", bus.alu_a_pc_ex_o, ex_m.apc);
      check("result_src_ex", bus.result_src_ex_o, ex_m.rs);
      check("reg_write_ex", bus.reg_write_ex_o, ex_m.rw);
      check("pc_src_ex", bus.pc_src_ex_o, pc);
      check("flush", bus.flush_o, pc != 0);
      check("illegal_ex", bus.illegal_ex_o, ex_m.ill);
      check("mem_write_mem", bus.mem_write_mem_o, mem_m.mw);
      check("reg_write_mem", bus.reg_write_mem_o, mem_m.rw);
      check("reg_write_wb", bus.reg_write_wb_o, wb_m.rw);
      check("result_src_wb", bus.result_src_wb_o, wb_m.rs);
      check("load_type_wb", bus.load_type_wb_o, wb_m.lt);
   endtask

   task automatic step(input logic [31:0] ins, input bit st, input bit z,
                       input bit l, input bit lu);
      exp_t nxt;
      @(negedge clk);
      bus.instr_i = ins;
      bus.stall_i = st;
      bus.zero_i  = z;
      bus.lt_i    = l;
      bus.ltu_i   = lu;
      #1;
      compare_all();
      nxt = (ref_pc(ex_m) != 0 || st) ? '0 : ref_dec(ins);
      wb_m  = mem_m;
      mem_m = ex_m;
      ex_m  = nxt;
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      ex_m = '0; mem_m = '0; wb_m = '0;
      compare_all();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) step(NOP, 0, 0, 0, 0);
   endtask

   logic [6:0] ops [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63,
                           7'h6F, 7'h67, 7'h37, 7'h17};

   initial begin
      logic [31:0] ins;
      bus.instr_i = SW;
      bus.stall_i = 0;
      bus.zero_i  = 0;
      bus.lt_i    = 0;
      bus.ltu_i   = 0;
      ex_m = '0; mem_m = '0; wb_m = '0;
      repeat (2) begin
         @(negedge clk);
         #1 compare_all();
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      step(SW, 0, 0, 0, 0);
      nops(3);
      step(ADDI, 0, 0, 0, 0);
      nops(3);
      step(BEQ, 0, 1, 0, 0);
      step(ADDI, 0, 1, 0, 0);
      step(ADDI, 0, 1, 0, 0);
      step(BEQ, 0, 0, 0, 0);
      step(NOP, 0, 0, 0, 0);
      step(BGEU, 0, 0, 0, 0);
      step(NOP, 0, 0, 0, 0);
      nops(2);
      step(LBU, 0, 0, 0, 0);
      nops(3);
      step(LBU, 1, 0, 0, 0);
      nops(3);
      step(JALR, 0, 0, 0, 0);
      step(NOP, 0, 0, 0, 0);
      nops(2);
      step(ADDI0, 0, 0, 0, 0);
      nops(3);
      step(AUIPC, 0, 0, 0, 0);
      step(LUI, 0, 0, 0, 0);
      nops(3);
      step(BADOP, 0, 0, 0, 0);
      nops(3);
      step(BEQ, 0, 1, 0, 0);
      step(ADDI, 1, 1, 0, 0);
      step(ADDI, 0, 1, 0, 0);
      nops(3);

      for (int i = 0; i < 600; i++) begin
         ins = $urandom;
         if ($urandom_range(9) == 0) ins[6:0] = 7'($urandom);
         else ins[6:0] = ops[$urandom_range(8)];
         if (i == 300) mid_reset();
         step(ins, $urandom_range(3) == 0, 1'($urandom), 1'($urandom),
              1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
